ingress_rx_buffer: RTL and testbench



---
 rtl/ingress_rx_buffer_pkg.sv | 29 ++
 rtl/ingress_rx_buffer_fifo.sv | 66 ++++++
 rtl/ingress_rx_buffer.sv | 190 +++++++++++++++++++
 tb/tb_ingress_rx_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_rx_buffer_pkg.sv
// Shared widths, FIFO entry layout and ingress FSM states for ingress_rx_buffer.
// Build option: define INGRESS_CUT_THROUGH_EN to release words before eop is buffered.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

package ingress_rx_buffer_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int PORT_NUB   = `PORT_NUB_TOTAL;
    localparam int PORT_WIDTH = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1;
    localparam int ENTRY_W    = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/ingress_rx_buffer_fifo.sv
// rx_word_fifo: synchronous FIFO with registered full/empty flags.
// Read data is the head entry, valid whenever empty_o is low.
module rx_word_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is legal only alongside a read.
    assign do_rd = rd_en_i & ~empty_q;
    assign do_wr = wr_en_i & (~full_q | do_rd);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/ingress_rx_buffer.sv
// Per-port ingress buffer: frames words into a local FIFO and releases one per owned TDM slot.
// Build option: INGRESS_CUT_THROUGH_EN (cut-through release); default is store-and-forward.
module ingress_rx_buffer
    import ingress_rx_buffer_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_sop,
    input  logic                  rx_eop,
    output logic                  wr_valid,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_sop,
    output logic                  wr_eop,
    output logic [PORT_WIDTH-1:0] wr_dest,
    output logic                  drop_pulse,
    output logic                  trunc_pulse
);

    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int FW = LW + 1;

    rx_state_e             st_q;
    logic [LW-1:0]         len_q;
    logic [FW-1:0]         frame_cnt_q;
    logic [PORT_WIDTH-1:0] slot_cnt_q;
    logic [PORT_WIDTH-1:0] dest_q;
    logic                  mid_q;
    logic                  wr_valid_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_sop_q;
    logic                  wr_eop_q;
    logic                  drop_q;
    logic                  trunc_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [ENTRY_W-1:0]    rd_raw;
    rx_entry_t             wr_entry;
    rx_entry_t             rd_entry;
    logic                  xfer;
    logic [PORT_WIDTH-1:0] hdr_dest;
    logic                  dest_range_ok;
    logic                  hdr_bad;
    logic                  len_last;
    logic                  last_slot;
    logic                  frame_in;
    logic                  frame_out;
    logic                  eligible;

    assign rx_ready = (st_q == ST_DROP) | ~fifo_full;
    assign xfer     = rx_valid & rx_ready;
    assign hdr_dest = rx_data[PORT_WIDTH-1:0];
    assign len_last = (len_q == LW'(FIFO_DEPTH - 1));

    // Out-of-range codes exist only when PORT_NUB is not a power of two.
    if ((1 << PORT_WIDTH) > PORT_NUB) begin : g_rng
        assign dest_range_ok = (32'(hdr_dest) < 32'(PORT_NUB));
    end else begin : g_all
        assign dest_range_ok = 1'b1;
    end

    assign hdr_bad = (hdr_dest == PORT_WIDTH'(PORT_ID)) | ~dest_range_ok;

    always_comb begin
        fifo_wr  = 1'b0;
        frame_in = 1'b0;
        wr_entry = '0;
        unique case (st_q)
            ST_IDLE: begin
                fifo_wr  = xfer & rx_sop & ~hdr_bad;
                frame_in = fifo_wr & rx_eop;
                wr_entry = '{sop: 1'b1, eop: rx_eop, data: rx_data};
            end
            ST_BODY: begin
                fifo_wr  = xfer;
                frame_in = xfer & (rx_eop | len_last);
                wr_entry = '{sop: 1'b0, eop: rx_eop | len_last, data: rx_data};
            end
            default: begin
                fifo_wr  = 1'b0;
                frame_in = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            len_q   <= '0;
            drop_q  <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            drop_q  <= 1'b0;
            trunc_q <= 1'b0;
            if (xfer) begin
                unique case (st_q)
                    ST_IDLE: begin
                        if (rx_sop) begin
                            len_q <= LW'(1);
                            if (hdr_bad) begin
                                drop_q <= 1'b1;
                                st_q   <= rx_eop ? ST_IDLE : ST_DROP;
                            end else if (!rx_eop) begin
                                st_q <= ST_BODY;
                            end
                        end
                    end
                    ST_BODY: begin
                        len_q <= len_q + 1'b1;
                        if (rx_eop) begin
                            st_q <= ST_IDLE;
                        end else if (len_last) begin
                            trunc_q <= 1'b1;
                            st_q    <= ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        if (rx_eop) st_q <= ST_IDLE;
                    end
                    default: st_q <= ST_IDLE;
                endcase
            end
        end
    end

    rx_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_entry),
        .rd_en_i   (fifo_rd),
        .rd_data_o (rd_raw),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign rd_entry  = rd_raw;
    assign last_slot = (slot_cnt_q == PORT_WIDTH'(PORT_NUB - 1));

`ifdef INGRESS_CUT_THROUGH_EN
    assign eligible = 1'b1;
`else
    assign eligible = (frame_cnt_q != '0) | mid_q;
`endif

    assign fifo_rd   = (slot_cnt_q == PORT_WIDTH'(PORT_ID)) & ~fifo_empty & eligible;
    assign frame_out = fifo_rd & rd_entry.eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q  <= '0;
            frame_cnt_q <= '0;
            mid_q       <= 1'b0;
            dest_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            wr_sop_q    <= 1'b0;
            wr_eop_q    <= 1'b0;
        end else begin
            slot_cnt_q  <= last_slot ? '0 : slot_cnt_q + 1'b1;
            frame_cnt_q <= frame_cnt_q + FW'(frame_in) - FW'(frame_out);
            wr_valid_q  <= fifo_rd;
            wr_data_q   <= fifo_rd ? rd_entry.data : '0;
            wr_sop_q    <= fifo_rd & rd_entry.sop;
            wr_eop_q    <= fifo_rd & rd_entry.eop;
            if (fifo_rd) mid_q <= ~rd_entry.eop;
            if (fifo_rd & rd_entry.sop) dest_q <= rd_entry.data[PORT_WIDTH-1:0];
        end
    end

    assign wr_valid    = wr_valid_q;
    assign wr_data     = wr_data_q;
    assign wr_sop      = wr_sop_q;
    assign wr_eop      = wr_eop_q;
    assign wr_dest     = dest_q;
    assign drop_pulse  = drop_q;
    assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_ingress_rx_buffer.sv
// Randomized bench for ingress_rx_buffer against a queue-based frame model.
// Honours INGRESS_CUT_THROUGH_EN in the model's release rule.
module tb_ingress_rx_buffer;
    import ingress_rx_buffer_pkg::*;

    localparam int PID   = 1;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_sop;
    logic                  rx_eop;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_sop;
    logic                  wr_eop;
    logic [PORT_WIDTH-1:0] wr_dest;
    logic                  drop_pulse;
    logic                  trunc_pulse;

    ingress_rx_buffer #(
        .PORT_ID    (PID),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_sop      (wr_sop),
        .wr_eop      (wr_eop),
        .wr_dest     (wr_dest),
        .drop_pulse  (drop_pulse),
        .trunc_pulse (trunc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sop;
        bit eop;
        int data;
    } word_t;

    // Model: words queued for release, plus frame-level bookkeeping.
    word_t q[$];
    int    m_state;
    int    m_len;
    int    m_frames;
    int    m_slot;
    int    m_dest;
    int    m_emitted;
    bit    m_mid;
    bit    e_valid, e_sop, e_eop, e_drop, e_trunc;
    int    e_data;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state   = 0;
        m_len     = 0;
        m_frames  = 0;
        m_slot    = 0;
        m_dest    = 0;
        m_mid     = 1'b0;
        e_valid   = 1'b0;
        e_sop     = 1'b0;
        e_eop     = 1'b0;
        e_drop    = 1'b0;
        e_trunc   = 1'b0;
        e_data    = 0;
    endtask

    function automatic bit model_ready();
        return (m_state == 2) || (q.size() < DEPTH);
    endfunction

    task automatic model_step(input bit v, input int d, input bit s, input bit e);
        bit    rdy;
        bit    pop;
        int    dst;
        word_t w;
        rdy = model_ready();
`ifdef INGRESS_CUT_THROUGH_EN
        pop = (m_slot == PID) && (q.size() > 0);
`else
        pop = (m_slot == PID) && (q.size() > 0) && (m_frames > 0 || m_mid);
`endif
        e_valid = 0; e_sop = 0; e_eop = 0; e_drop = 0; e_trunc = 0; e_data = 0;
        if (pop) begin
            w       = q.pop_front();
            e_valid = 1;
            e_sop   = w.sop;
            e_eop   = w.eop;
            e_data  = w.data;
            if (w.sop) m_dest = w.data % (1 << PORT_WIDTH);
            if (w.eop) m_frames--;
            m_mid = !w.eop;
            m_emitted++;
        end
        if (v && rdy) begin
            w.data = d % (1 << DATA_WIDTH);
            case (m_state)
                0: if (s) begin
                    dst = d % (1 << PORT_WIDTH);
                    if (dst == PID || dst >= PORT_NUB) begin
                        e_drop  = 1;
                        m_state = e ? 0 : 2;
                    end else begin
                        w.sop = 1; w.eop = e;
                        q.push_back(w);
                        m_len = 1;
                        if (e) m_frames++;
                        else m_state = 1;
                    end
                end
                1: begin
                    m_len++;
                    w.sop = 0;
                    w.eop = e || (m_len == DEPTH);
                    q.push_back(w);
                    if (w.eop) m_frames++;
                    if (e) m_state = 0;
                    else if (m_len == DEPTH) begin
                        e_trunc = 1;
                        m_state = 2;
                    end
                end
                default: if (e) m_state = 0;
            endcase
        end
        m_slot = (m_slot + 1) % PORT_NUB;
    endtask

    task automatic compare();
        check("rx_ready", int'(rx_ready), int'(model_ready()));
        check("wr_valid", int'(wr_valid), int'(e_valid));
        check("wr_data", int'(wr_data), e_data);
        check("wr_sop", int'(wr_sop), int'(e_sop));
        check("wr_eop", int'(wr_eop), int'(e_eop));
        check("wr_dest", int'(wr_dest), m_dest);
        check("drop_pulse", int'(drop_pulse), int'(e_drop));
        check("trunc_pulse", int'(trunc_pulse), int'(e_trunc));
    endtask

    task automatic tick(input bit v, input int d, input bit s, input bit e, output bit acc);
        acc      = v && model_ready();
        rx_valid = v;
        rx_data  = DATA_WIDTH'(d);
        rx_sop   = s;
        rx_eop   = e;
        model_step(v, d, s, e);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(0, 255), 1'b0, 1'b0, acc);
    endtask

    task automatic send_word(input int d, input bit s, input bit e);
        bit acc;
        int tries;
        tries = 0;
        do begin
            tick(1'b1, d, s, e, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int len, input int dest, input bit gaps);
        int d;
        bit s;
        for (int i = 0; i < len; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            if (i == 0) d = ($urandom_range(0, 63) << 2) | dest;
            else d = $urandom_range(0, 255);
            s = (i == 0) || (gaps && $urandom_range(0, 9) == 0);
            send_word(d, s, i == len - 1);
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
        model_reset();
        m_emitted = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();

        // Three-word frame to port 2.
        send_word(8'h02, 1'b1, 1'b0);
        send_word(8'hA1, 1'b0, 1'b0);
        send_word(8'hA2, 1'b0, 1'b1);
        idle(16);

        // Header addressed to own port: dropped.
        send_word(8'h01, 1'b1, 1'b0);
        send_word(8'h55, 1'b0, 1'b0);
        send_word(8'h66, 1'b0, 1'b1);
        idle(4);

        // Overlong frame is truncated at DEPTH words.
        send_frame(10, 2, 1'b0);
        idle(40);

        // Back-to-back frames fill the FIFO.
        for (int f = 0; f < 4; f++) send_frame(4, (f % 2 == 0) ? 0 : 3, 1'b0);
        idle(80);

        // Single-word frame.
        send_frame(1, 3, 1'b0);
        idle(8);

        // Reset in the middle of emitting a 5-word frame.
        send_frame(5, 0, 1'b0);
        m_emitted = 0;
        n = 0;
        while (!(e_valid && m_emitted >= 2) && n < 100) begin
            idle(1);
            n++;
        end
        check("rst_emission_seen", int'(e_valid), 1);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("rst_wr_valid", int'(wr_valid), 0);
        check("rst_rx_ready", int'(rx_ready), 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        send_frame(3, 2, 1'b0);
        idle(20);

        // Randomized traffic: lengths, destinations, gaps, stray words.
        for (int f = 0; f < 60; f++) begin
            if (m_state == 0 && $urandom_range(0, 4) == 0)
                send_word($urandom_range(0, 255), 1'b0, 1'($urandom_range(0, 1)));
            send_frame($urandom_range(1, 11), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        idle(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
